// File: rtl/fetch_pc_sequencer_pkg.sv
// Shared definitions for the fetch-PC sequencer: FSM encodings and the
// fixed instruction size used for sequential advance and return addresses.
package fetch_pc_sequencer_pkg;

  typedef enum logic [0:0] {
    ST_RUN          = 1'b0,
    ST_WAIT_RESOLVE = 1'b1
  } fetch_state_e;

  localparam int unsigned INST_BYTES = 4;

endpackage

// File: rtl/fetch_pc_sequencer_ras.sv
// Circular return address stack. A push into a full stack overwrites the
// oldest entry, and count saturates at DEPTH.
module fetch_pc_sequencer_ras #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         push_data,
  output logic [WIDTH-1:0]         top,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] ptr;  // next free slot; top lives at ptr-1

  assign top = mem[ptr - PTR_W'(1)];

  // NOTE: the entries are not reset; count guards every read, so clearing
  // the storage would only add reset fan-out without changing behaviour.
  always_ff @(posedge clk) begin
    if (push) mem[ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, matching the hardware regardless of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= '0;
      count <= '0;
    end else if (push) begin
      ptr   <= ptr + PTR_W'(1);
      count <= (count == FULL_COUNT) ? FULL_COUNT : count + 1'b1;
    end else if (pop && count != '0) begin
      ptr   <= ptr - PTR_W'(1);
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/fetch_pc_sequencer.sv
// Front-end fetch-PC controller: sequential fetch, static BTFN prediction,
// direct-jump redirect, RAS-predicted returns, and backend flush override.
module fetch_pc_sequencer
  import fetch_pc_sequencer_pkg::*;
#(
  parameter int unsigned    ADDR_WIDTH = 32,
  parameter int unsigned    RAS_DEPTH  = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       fetch_req_valid,
  input  logic                       fetch_req_ready,
  output logic [ADDR_WIDTH-1:0]      fetch_pc,
  input  logic                       inst_valid,
  input  logic [ADDR_WIDTH-1:0]      inst_pc,
  input  logic                       pdec_branch,
  input  logic                       pdec_jal,
  input  logic                       pdec_jalr,
  input  logic                       pdec_call,
  input  logic                       pdec_ret,
  input  logic [ADDR_WIDTH-1:0]      pdec_pc,
  input  logic                       flush_valid,
  input  logic [ADDR_WIDTH-1:0]      flush_pc,
  output logic                       redirect_valid,
  output logic [ADDR_WIDTH-1:0]      redirect_pc,
  output logic                       stall_resolve,
  output logic [$clog2(RAS_DEPTH):0] ras_count
);

  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(INST_BYTES);

  fetch_state_e          state;
  logic                  pdec_act;
  logic                  jal_hit, br_hit, ret_hit, jalr_stall;
  logic                  ras_push, ras_pop;
  logic [ADDR_WIDTH-1:0] ras_top;

  fetch_pc_sequencer_ras #(
    .DEPTH (RAS_DEPTH),
    .WIDTH (ADDR_WIDTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (inst_pc + STEP),
    .top       (ras_top),
    .count     (ras_count)
  );

  assign fetch_req_valid = !rst && state == ST_RUN;
  assign stall_resolve   = !rst && state == ST_WAIT_RESOLVE;

  // NOTE: every output of this block gets a default first so no path leaves
  // a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    pdec_act       = 1'b0;
    jal_hit        = 1'b0;
    br_hit         = 1'b0;
    ret_hit        = 1'b0;
    jalr_stall     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = fetch_pc;

    // A flush suppresses pre-decode, so no push/pop happens in that cycle.
    pdec_act = !rst && state == ST_RUN && inst_valid && !flush_valid;
    if (pdec_act) begin
      if (pdec_jal)                                   jal_hit    = 1'b1;
      else if (pdec_branch && pdec_pc < inst_pc)      br_hit     = 1'b1;
      else if (pdec_jalr && pdec_ret && ras_count != '0) ret_hit = 1'b1;
      else if (pdec_jalr)                             jalr_stall = 1'b1;
    end

    if (!rst && flush_valid) begin
      redirect_valid = 1'b1;
      redirect_pc    = flush_pc;
    end else if (jal_hit || br_hit) begin
      redirect_valid = 1'b1;
      redirect_pc    = pdec_pc;
    end else if (ret_hit) begin
      redirect_valid = 1'b1;
      redirect_pc    = ras_top;
    end
  end

  assign ras_push = jal_hit && pdec_call;
  assign ras_pop  = ret_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_RUN;
      fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      // Redirect wins over a same-cycle handshake; the accepted PC is dropped.
      state    <= ST_RUN;
      fetch_pc <= redirect_pc;
    end else if (jalr_stall) begin
      state    <= ST_WAIT_RESOLVE;
    end else if (fetch_req_valid && fetch_req_ready) begin
      fetch_pc <= fetch_pc + STEP;
    end
  end

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Directed bench for fetch_pc_sequencer with hand-computed expectations.
module tb_fetch_pc_sequencer;

  localparam int RAS_DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req_valid, fetch_req_ready;
  logic [31:0] fetch_pc;
  logic        inst_valid;
  logic [31:0] inst_pc, pdec_pc, flush_pc, redirect_pc;
  logic        pdec_branch, pdec_jal, pdec_jalr, pdec_call, pdec_ret;
  logic        flush_valid, redirect_valid, stall_resolve;
  logic [3:0]  ras_count;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  fetch_pc_sequencer #(.ADDR_WIDTH(32), .RAS_DEPTH(RAS_DEPTH), .RESET_PC(32'h0)) dut (
    .clk             (clk),
    .rst             (rst),
    .fetch_req_valid (fetch_req_valid),
    .fetch_req_ready (fetch_req_ready),
    .fetch_pc        (fetch_pc),
    .inst_valid      (inst_valid),
    .inst_pc         (inst_pc),
    .pdec_branch     (pdec_branch),
    .pdec_jal        (pdec_jal),
    .pdec_jalr       (pdec_jalr),
    .pdec_call       (pdec_call),
    .pdec_ret        (pdec_ret),
    .pdec_pc         (pdec_pc),
    .flush_valid     (flush_valid),
    .flush_pc        (flush_pc),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .stall_resolve   (stall_resolve),
    .ras_count       (ras_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Advance one edge, then settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    inst_valid  = 1'b0;
    pdec_branch = 1'b0;
    pdec_jal    = 1'b0;
    pdec_jalr   = 1'b0;
    pdec_call   = 1'b0;
    pdec_ret    = 1'b0;
    inst_pc     = '0;
    pdec_pc     = '0;
    flush_valid = 1'b0;
    flush_pc    = '0;
  endtask

  task automatic pdec(input logic jal, input logic call, input logic br,
                      input logic jalr, input logic ret,
                      input logic [31:0] ipc, input logic [31:0] tgt);
    inst_valid  = 1'b1;
    pdec_jal    = jal;
    pdec_call   = call;
    pdec_branch = br;
    pdec_jalr   = jalr;
    pdec_ret    = ret;
    inst_pc     = ipc;
    pdec_pc     = tgt;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    fetch_req_ready = 1'b1;
    clear_in();
    tick();
    tick();
    check("rst_req_valid", 32'(fetch_req_valid), 32'd0);
    check("rst_redirect",  32'(redirect_valid),  32'd0);
    check("rst_stall",     32'(stall_resolve),   32'd0);
    check("rst_pc",        fetch_pc,             32'h0);
    check("rst_ras_count", 32'(ras_count),       32'd0);

    // Sequential fetch after reset release.
    rst = 1'b0;
    #1;
    check("seq_req_valid", 32'(fetch_req_valid), 32'd1);
    check("seq_pc0", fetch_pc, 32'h0);
    tick(); check("seq_pc4", fetch_pc, 32'h4);
    tick(); check("seq_pc8", fetch_pc, 32'h8);
    tick(); check("seq_pcC", fetch_pc, 32'hC);
    check("seq_no_redirect", 32'(redirect_valid), 32'd0);

    fetch_req_ready = 1'b0;
    tick(); check("hold_no_ready", fetch_pc, 32'hC);
    fetch_req_ready = 1'b1;

    // Call then return through the RAS.
    pdec(1, 1, 0, 0, 0, 32'h100, 32'h400);
    check("call_redirect",    32'(redirect_valid), 32'd1);
    check("call_redirect_pc", redirect_pc, 32'h400);
    tick(); clear_in();
    check("call_pc",    fetch_pc, 32'h400);
    check("call_count", 32'(ras_count), 32'd1);

    pdec(0, 0, 0, 1, 1, 32'h410, 32'h0);
    check("ret_redirect_pc", redirect_pc, 32'h104);
    tick(); clear_in();
    check("ret_pc",    fetch_pc, 32'h104);
    check("ret_count", 32'(ras_count), 32'd0);

    // Backward branch taken (handshake discarded), forward branch ignored.
    pdec(0, 0, 1, 0, 0, 32'h200, 32'h1F0);
    check("bwd_redirect_pc", redirect_pc, 32'h1F0);
    tick(); clear_in();
    check("bwd_pc", fetch_pc, 32'h1F0);
    pdec(0, 0, 1, 0, 0, 32'h200, 32'h220);
    check("fwd_no_redirect", 32'(redirect_valid), 32'd0);
    tick(); clear_in();
    check("fwd_pc_seq", fetch_pc, 32'h1F4);

    // Non-return JALR stalls; inst_valid ignored until flush.
    pdec(0, 0, 0, 1, 0, 32'h300, 32'h0);
    check("jalr_no_redirect", 32'(redirect_valid), 32'd0);
    tick(); clear_in();
    check("wait_req_valid", 32'(fetch_req_valid), 32'd0);
    check("wait_stall",     32'(stall_resolve),   32'd1);
    check("wait_pc_hold",   fetch_pc, 32'h1F4);
    pdec(1, 1, 0, 0, 0, 32'h310, 32'h600);
    check("wait_ignores_inst", 32'(redirect_valid), 32'd0);
    tick(); clear_in();
    check("wait_still_stall", 32'(stall_resolve), 32'd1);
    check("wait_no_push",     32'(ras_count), 32'd0);
    flush_valid = 1'b1; flush_pc = 32'h800; #1;
    check("flush_redirect_pc", redirect_pc, 32'h800);
    tick(); clear_in();
    check("flush_pc",    fetch_pc, 32'h800);
    check("flush_run",   32'(fetch_req_valid), 32'd1);

    // Flush beats a same-cycle call.
    flush_valid = 1'b1; flush_pc = 32'h900;
    pdec(1, 1, 0, 0, 0, 32'h500, 32'h700);
    check("flush_prio_pc", redirect_pc, 32'h900);
    tick(); clear_in();
    check("flush_prio_fetch", fetch_pc, 32'h900);
    check("flush_prio_count", 32'(ras_count), 32'd0);

    // RAS_DEPTH+1 calls: oldest (0x4) overwritten, count saturates.
    for (int i = 0; i <= RAS_DEPTH; i++) begin
      pdec(1, 1, 0, 0, 0, 32'(i * 16), 32'h1000);
      tick(); clear_in();
    end
    check("ras_sat_count", 32'(ras_count), 32'(RAS_DEPTH));
    for (int i = RAS_DEPTH; i >= 1; i--) begin
      pdec(0, 0, 0, 1, 1, 32'h2000, 32'h0);
      check($sformatf("ras_pop_%0d", i), redirect_pc, 32'(i * 16 + 4));
      tick(); clear_in();
    end
    check("ras_empty", 32'(ras_count), 32'd0);
    pdec(0, 0, 0, 1, 1, 32'h2000, 32'h0);
    check("ret_empty_no_redirect", 32'(redirect_valid), 32'd0);
    tick(); clear_in();
    check("ret_empty_stall", 32'(stall_resolve), 32'd1);

    // Reset wins mid-WAIT_RESOLVE.
    rst = 1'b1; #1;
    check("rst_mid_stall", 32'(stall_resolve), 32'd0);
    tick();
    rst = 1'b0; #1;
    check("rst_mid_pc",  fetch_pc, 32'h0);
    check("rst_mid_run", 32'(fetch_req_valid), 32'd1);

    // PC wraps modulo 2^32.
    flush_valid = 1'b1; flush_pc = 32'hFFFF_FFFC; #1;
    tick(); clear_in();
    check("wrap_pre", fetch_pc, 32'hFFFF_FFFC);
    tick();
    check("wrap_post", fetch_pc, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
